// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// One transaction in flight at a time: grant in IDLE, operate in EXEC, hold the result in RESP.
module alu_arbiter (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iReqV0,
  input  logic        iReqV1,
  input  logic [3:0]  iOp0,
  input  logic [3:0]  iOp1,
  input  logic [31:0] iA0,
  input  logic [31:0] iA1,
  input  logic [31:0] iB0,
  input  logic [31:0] iB1,
  output logic        oReqR0,
  output logic        oReqR1,
  output logic [3:0]  oAluOP,
  output logic [31:0] oAluA,
  output logic [31:0] oAluB,
  input  logic [31:0] iAluC,
  output logic        oRspV0,
  output logic        oRspV1,
  output logic [31:0] oRspC,
  input  logic        iRspR0,
  input  logic        iRspR1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   owner;     // requester that owns the transaction in flight
  logic   ptr;       // requester favoured when both are valid
  logic   grant0;
  logic   grant1;
  logic   rsp_done;

  // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    // Grants are masked while reset is held so no requester sees an ack that cannot be taken.
    if (state == IDLE && nRst) begin
      if (iReqV0 && (!iReqV1 || !ptr)) begin
        grant0 = 1'b1;
      end else if (iReqV1) begin
        grant1 = 1'b1;
      end
    end
  end

  assign oReqR0   = grant0;
  assign oReqR1   = grant1;
  assign rsp_done = (state == RESP) && (owner ? iRspR1 : iRspR0);

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      ptr    <= 1'b0;
      oAluOP <= 4'h0;
      oAluA  <= 32'h0;
      oAluB  <= 32'h0;
      oRspC  <= 32'h0;
      oRspV0 <= 1'b0;
      oRspV1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            oAluOP <= iOp0;
            oAluA  <= iA0;
            oAluB  <= iB0;
            owner  <= 1'b0;
            state  <= EXEC;
          end else if (grant1) begin
            oAluOP <= iOp1;
            oAluA  <= iA1;
            oAluB  <= iB1;
            owner  <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          oRspC  <= iAluC;
          oRspV0 <= ~owner;
          oRspV1 <= owner;
          state  <= RESP;
        end
        RESP: begin
          // Only the owner's ready completes the response; the other ready is ignored.
          if (rsp_done) begin
            oRspV0 <= 1'b0;
            oRspV1 <= 1'b0;
            ptr    <= ~owner;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU, a scoreboard of expected
// responses filled on each accept, and directed sequences for the arbitration corner cases.
module tb_alu_arbiter;

  logic        iClk = 1'b0;
  logic        nRst;
  logic        iReqV0, iReqV1;
  logic [3:0]  iOp0, iOp1;
  logic [31:0] iA0, iA1, iB0, iB1;
  logic        oReqR0, oReqR1;
  logic [3:0]  oAluOP;
  logic [31:0] oAluA, oAluB;
  logic [31:0] iAluC;
  logic        oRspV0, oRspV1;
  logic [31:0] oRspC;
  logic        iRspR0, iRspR1;

  typedef struct packed {
    logic        owner;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_arbiter dut (
    .iClk   (iClk),
    .nRst   (nRst),
    .iReqV0 (iReqV0),
    .iReqV1 (iReqV1),
    .iOp0   (iOp0),
    .iOp1   (iOp1),
    .iA0    (iA0),
    .iA1    (iA1),
    .iB0    (iB0),
    .iB1    (iB1),
    .oReqR0 (oReqR0),
    .oReqR1 (oReqR1),
    .oAluOP (oAluOP),
    .oAluA  (oAluA),
    .oAluB  (oAluB),
    .iAluC  (iAluC),
    .oRspV0 (oRspV0),
    .oRspV1 (oRspV1),
    .oRspC  (oRspC),
    .iRspR0 (iRspR0),
    .iRspR1 (iRspR1)
  );

  always #5 iClk = ~iClk;

  // Reference ALU; unsupported codes return zero.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a | b;
      4'h4:    return a & b;
      4'h5:    return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  always_comb iAluC = alu_f(oAluOP, oAluA, oAluB);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Scoreboard: push on every accept, pop on every completed response.
  always @(negedge iClk) begin
    if (nRst) begin
      exp_t e;
      if (oReqR0 || oReqR1) check("grant_excl", 32'(oReqR0 & oReqR1), 32'd0);
      if (oRspV0 || oRspV1) check("rsp_excl", 32'(oRspV0 & oRspV1), 32'd0);
      if (oReqR0) begin
        e.owner = 1'b0;
        e.res   = alu_f(iOp0, iA0, iB0);
        sb.push_back(e);
      end else if (oReqR1) begin
        e.owner = 1'b1;
        e.res   = alu_f(iOp1, iA1, iB1);
        sb.push_back(e);
      end
      if (oRspV0 ? iRspR0 : (oRspV1 && iRspR1)) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_owner", 32'(oRspV1), 32'(e.owner));
          check("sb_result", oRspC, e.res);
        end
      end
    end
  end

  // A reset discards whatever was in flight.
  always @(negedge nRst) sb.delete();

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic wait_grant(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge iClk);
      if (oReqR0) begin who = 0; break; end
      if (oReqR1) begin who = 1; break; end
    end
  endtask

  task automatic wait_rsp(output int who, output logic [31:0] c);
    who = -1;
    c   = 32'hx;
    for (int i = 0; i < 20; i++) begin
      @(negedge iClk);
      if (oRspV0) begin who = 0; c = oRspC; break; end
      if (oRspV1) begin who = 1; c = oRspC; break; end
    end
  endtask

  initial begin
    int          who;
    int          seen;
    logic [31:0] c, c_hold;

    nRst = 1'b0;
    iReqV0 = 1'b0; iReqV1 = 1'b0;
    iOp0 = 4'h0; iOp1 = 4'h0;
    iA0 = 32'h0; iA1 = 32'h0; iB0 = 32'h0; iB1 = 32'h0;
    iRspR0 = 1'b1; iRspR1 = 1'b1;
    #1;
    check("rst_aluop", 32'(oAluOP), 32'd0);
    check("rst_alua", oAluA, 32'd0);
    check("rst_alub", oAluB, 32'd0);
    check("rst_rspc", oRspC, 32'd0);
    check("rst_rspv", 32'({oRspV1, oRspV0}), 32'd0);
    check("rst_reqr", 32'({oReqR1, oReqR0}), 32'd0);
    step(); step();
    nRst = 1'b1;

    // Single request, latency and ALU drive.
    step();
    iReqV0 = 1'b1; iOp0 = 4'h0; iA0 = 32'd5; iB0 = 32'd7;
    wait_grant(who);
    check("single_grant", 32'(who), 32'd0);
    check("single_no_req1", 32'(oReqR1), 32'd0);
    step();
    iReqV0 = 1'b0;
    @(negedge iClk);
    check("single_aluop", 32'(oAluOP), 32'd0);
    check("single_alua", oAluA, 32'd5);
    check("single_alub", oAluB, 32'd7);
    check("single_no_rsp_in_exec", 32'(oRspV0), 32'd0);
    @(negedge iClk);
    check("single_rspv0", 32'(oRspV0), 32'd1);
    check("single_rspc", oRspC, 32'd12);
    @(negedge iClk);
    check("single_done", 32'(oRspV0), 32'd0);
    check("single_alu_hold", oAluA, 32'd5);

    // Contention from a fresh reset: 0, then 1, then 0 again.
    step();
    nRst = 1'b0;
    step();
    nRst = 1'b1;
    iReqV0 = 1'b1; iOp0 = 4'h1; iA0 = 32'd10;   iB0 = 32'd3;
    iReqV1 = 1'b1; iOp1 = 4'h4; iA1 = 32'hF0;   iB1 = 32'h3C;
    wait_grant(who);
    check("cont_first", 32'(who), 32'd0);
    wait_rsp(who, c);
    check("cont_rsp1_owner", 32'(who), 32'd0);
    check("cont_rsp1_c", c, 32'd7);
    wait_grant(who);
    check("cont_second", 32'(who), 32'd1);
    wait_rsp(who, c);
    check("cont_rsp2_owner", 32'(who), 32'd1);
    check("cont_rsp2_c", c, 32'h30);
    wait_grant(who);
    check("cont_third", 32'(who), 32'd0);
    step();
    iReqV0 = 1'b0; iReqV1 = 1'b0;
    wait_rsp(who, c);
    check("cont_rsp3_c", c, 32'd7);

    // Backpressure on requester 0 while requester 1 waits.
    step();
    iRspR0 = 1'b0;
    iReqV0 = 1'b1; iOp0 = 4'h5; iA0 = 32'hA5A5_0000; iB0 = 32'h0000_5A5A;
    wait_grant(who);
    check("bp_grant", 32'(who), 32'd0);
    step();
    iReqV0 = 1'b0;
    iReqV1 = 1'b1; iOp1 = 4'h2; iA1 = 32'h0F00; iB1 = 32'h00F0;
    wait_rsp(who, c_hold);
    check("bp_owner", 32'(who), 32'd0);
    check("bp_value", c_hold, 32'hA5A5_5A5A);
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      check("bp_rspv_held", 32'(oRspV0), 32'd1);
      check("bp_rspc_held", oRspC, c_hold);
      check("bp_no_grant", 32'({oReqR1, oReqR0}), 32'd0);
    end
    step();
    iRspR0 = 1'b1;
    @(negedge iClk);
    check("bp_release_rspv", 32'(oRspV0), 32'd1);
    @(negedge iClk);
    check("bp_idle_rspv", 32'(oRspV0), 32'd0);
    check("bp_idle_grant1", 32'(oReqR1), 32'd1);
    step();
    iReqV1 = 1'b0;
    wait_rsp(who, c);
    check("bp_req1_c", c, 32'h0FF0);

    // Reset while requester 1 is held in RESP.
    step();
    iRspR1 = 1'b0;
    iReqV1 = 1'b1; iOp1 = 4'h0; iA1 = 32'd100; iB1 = 32'd23;
    wait_grant(who);
    step();
    iReqV1 = 1'b0;
    wait_rsp(who, c);
    check("rr_owner", 32'(who), 32'd1);
    check("rr_value", c, 32'd123);
    #2;
    nRst = 1'b0;
    #1;
    check("rr_rspv1_cleared", 32'(oRspV1), 32'd0);
    check("rr_rspc_cleared", oRspC, 32'd0);
    check("rr_alua_cleared", oAluA, 32'd0);
    step();
    nRst = 1'b1;
    iRspR1 = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge iClk);
      if (oRspV0 || oRspV1) seen++;
    end
    check("rr_no_rsp_after_release", 32'(seen), 32'd0);

    // Unsupported op from requester 1 alone; pointer then favours requester 0.
    step();
    iReqV1 = 1'b1; iOp1 = 4'hF; iA1 = 32'd1; iB1 = 32'd1;
    wait_grant(who);
    check("unsup_grant", 32'(who), 32'd1);
    step();
    iReqV1 = 1'b0;
    @(negedge iClk);
    check("unsup_op_pass", 32'(oAluOP), 32'hF);
    wait_rsp(who, c);
    check("unsup_owner", 32'(who), 32'd1);
    check("unsup_c", c, 32'd0);
    step();
    iReqV0 = 1'b1; iOp0 = 4'h0; iA0 = 32'd2; iB0 = 32'd2;
    iReqV1 = 1'b1; iOp1 = 4'h0; iA1 = 32'd3; iB1 = 32'd3;
    wait_grant(who);
    check("unsup_then_req0", 32'(who), 32'd0);
    step();
    iReqV0 = 1'b0;
    wait_grant(who);
    check("unsup_then_req1", 32'(who), 32'd1);
    step();
    iReqV1 = 1'b0;
    wait_rsp(who, c);
    check("unsup_tail_c", c, 32'd6);

    // Stray ready from the non-owner.
    step();
    iRspR0 = 1'b0; iRspR1 = 1'b1;
    iReqV0 = 1'b1; iOp0 = 4'h1; iA0 = 32'd0; iB0 = 32'd1;
    wait_grant(who);
    check("stray_grant", 32'(who), 32'd0);
    step();
    iReqV0 = 1'b0;
    wait_rsp(who, c);
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      check("stray_rspv0_held", 32'(oRspV0), 32'd1);
      check("stray_rspc", oRspC, 32'hFFFF_FFFF);
    end
    step();
    iRspR0 = 1'b1;
    @(negedge iClk);
    @(negedge iClk);
    check("stray_done", 32'(oRspV0), 32'd0);

    // No ack while reset is held; first grant only after release.
    step();
    nRst = 1'b0;
    iReqV0 = 1'b1; iOp0 = 4'h0; iA0 = 32'd40; iB0 = 32'd2;
    #1;
    check("rst_no_grant", 32'(oReqR0), 32'd0);
    step();
    check("rst_no_grant_edge", 32'(oReqR0), 32'd0);
    nRst = 1'b1;
    wait_grant(who);
    check("post_rst_grant", 32'(who), 32'd0);
    step();
    iReqV0 = 1'b0;
    wait_rsp(who, c);
    check("post_rst_c", c, 32'd42);
    step(); step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
